// File: rtl/regq_pkg.sv
// Shared constants for the Q register: shift-mode codes and FSM state encoding.
package regq_pkg;

    localparam logic [1:0] MODE_LSR = 2'b00;
    localparam logic [1:0] MODE_ASR = 2'b01;
    localparam logic [1:0] MODE_LSL = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/regq_shift_step.sv
// One combinational shift step of the Q register; shared by single-step and sequence paths.
module regq_shift_step
    import regq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       mode,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q_next,
    output logic             out_bit
);

    always_comb begin
        q_next  = q;
        out_bit = q[0];
        case (mode)
            MODE_LSR: q_next = {serial_in, q[WIDTH-1:1]};
            MODE_ASR: q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            MODE_LSL: begin
                q_next  = {q[WIDTH-2:0], serial_in};
                out_bit = q[WIDTH-1];
            end
            MODE_ROR: q_next = {q[0], q[WIDTH-1:1]};
            default:  q_next = q;
        endcase
    end

endmodule

// File: rtl/regq_seq.sv
// Q register with parallel load, single-step shift and a self-timed N-step shift sequence.
module regq_seq
    import regq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] entQ,
    input  logic             CargaQ,
    input  logic             DesplazaQ,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic [1:0]       mode,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam logic [AMT_W-1:0] CNT_ZERO = '0;
    localparam logic [AMT_W-1:0] CNT_ONE  = AMT_W'(1);

    logic [WIDTH-1:0] r_q;
    logic             r_sout;
    logic             r_busy;
    logic             r_done;
    logic [0:0]       r_state;
    logic [AMT_W-1:0] r_cnt;
    logic [1:0]       r_mode;

    logic [1:0]       w_mode;
    logic [WIDTH-1:0] w_q_next;
    logic             w_out_bit;

    // A running sequence uses the latched mode so live mode changes cannot disturb it.
    assign w_mode = (r_state == ST_RUN) ? r_mode : mode;

    regq_shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .q         (r_q),
        .mode      (w_mode),
        .serial_in (serial_in),
        .q_next    (w_q_next),
        .out_bit   (w_out_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q     <= '0;
            r_sout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
            r_mode  <= MODE_LSR;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (CargaQ) begin
                    r_q <= entQ;
                end else if (start) begin
                    if (amount != CNT_ZERO) begin
                        r_mode  <= mode;
                        r_cnt   <= amount;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_done <= 1'b1;
                    end
                end else if (DesplazaQ) begin
                    r_q    <= w_q_next;
                    r_sout <= w_out_bit;
                end
            end else begin
                // A load during a sequence aborts it without signalling completion.
                if (CargaQ) begin
                    r_q     <= entQ;
                    r_busy  <= 1'b0;
                    r_cnt   <= CNT_ZERO;
                    r_state <= ST_IDLE;
                end else begin
                    r_q    <= w_q_next;
                    r_sout <= w_out_bit;
                    r_cnt  <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
            end
        end
    end

    assign q          = r_q;
    assign serial_out = r_sout;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: doc/regq_seq.md
Name: regq_seq

Overview:
- Parametrised successor to the control unit's Q register: a WIDTH-bit register with parallel load, single-step shift and a self-timed multi-step shift sequence.
- Supports four shift modes, a serial input, a registered serial output and a busy/done handshake.
- Used by the shift-add multiplier and divider datapaths so the control FSM can issue one "shift N" command instead of N single shifts.

Parameters:
- WIDTH, 8, register width in bits (≥2).
- AMT_W, 3, width of the shift-amount field; maximum sequence length is 2^AMT_W-1. Must satisfy 2^AMT_W-1 ≤ WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- entQ  in  WIDTH  parallel load data.
- CargaQ  in  1  parallel load request.
- DesplazaQ  in  1  single-step shift request (idle only).
- start  in  1  begin multi-step sequence.
- amount  in  AMT_W  number of steps for the sequence.
- mode  in  2  shift mode: 00 logical right, 01 arithmetic right, 10 logical left, 11 rotate right.
- serial_in  in  1  bit inserted at the vacated end in logical modes.
- q  out  WIDTH  register contents.
- serial_out  out  1  last bit shifted out (registered).
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at sequence completion.

Behaviour:
- Reset (reset=0, asynchronous, no clock needed): q=0, serial_out=0, busy=0, done=0, step counter=0, FSM=IDLE. Reset mid-sequence aborts it with no done pulse.
- Shift step definitions (s = serial_in):
  - 00: q <= {s, q[W-1:1]}; out bit q[0].
  - 01: q <= {q[W-1], q[W-1:1]}; out bit q[0].
  - 10: q <= {q[W-2:0], s}; out bit q[W-1].
  - 11: q <= {q[0], q[W-1:1]}; out bit q[0].
  - serial_out updates only on a step and holds otherwise.
- FSM states: IDLE and RUN.
- IDLE, per edge, in priority order:
  1. CargaQ=1: q <= entQ.
  2. start=1 with amount=N≥1: latch mode into mode_r, counter <= N, busy <= 1, go to RUN. q is unchanged at this edge.
  3. start=1 with amount=0: done <= 1 for one cycle. q, busy and state are unchanged.
  4. DesplazaQ=1: one step using the live mode input.
  5. Otherwise: hold.
- RUN, per edge:
  - CargaQ=1: q <= entQ, busy <= 0, go to IDLE, no done pulse (abort).
  - Otherwise: one step using mode_r, counter decrements. When counter reaches 1 (the last step), busy <= 0, done <= 1, go to IDLE.
  - start and DesplazaQ are ignored in RUN. mode and amount changes have no effect on a running sequence.
- Timing: if start is sampled at edge k, shifts occur at edges k+1..k+N. After edge k+N, q holds the final value, busy=0 and done=1 for exactly one cycle. Total latency is N+1 edges.
- done is registered and is deasserted at every edge that does not complete a sequence.
- Back-to-back: start may be asserted in the same cycle that done=1 (FSM is already IDLE); the new sequence is accepted.
- CargaQ and start together in IDLE: the load wins and start is dropped.

Decomposition:
- Package regq_pkg holds:
  - Mode constants: MODE_LSR=2'b00, MODE_ASR=2'b01, MODE_LSL=2'b10, MODE_ROR=2'b11.
  - FSM state encoding: IDLE, RUN.
- Sub-module regq_shift_step: combinational; inputs q, mode, serial_in; outputs next q and the shifted-out bit. It is instanced once and shared by the single-step and sequence paths.

Test Plan:
- Reset: drive reset=0 asynchronously mid-cycle after loading 8'hFF → q=8'h00, serial_out=0, busy=0, done=0 immediately, with no clock edge.
- Arithmetic right: load 8'hB5, then start amount=3 mode=01 → busy=1 for 3 cycles; after the 4th edge q=8'hF6, serial_out=1, done=1 for one cycle.
- Rotate and single step:
  - load 8'hB5, start amount=4 mode=11 → q=8'h5B.
  - then DesplazaQ=1 mode=10 serial_in=1 → q=8'hB7, serial_out=0.
- Abort: load 8'h01, start amount=7 mode=00 serial_in=0; assert CargaQ entQ=8'h3C on the 2nd RUN edge → q=8'h3C, busy=0 next cycle, done never asserted.
- Corner cases:
  - start amount=0 → done=1 one cycle after the start edge, q unchanged, busy stays 0.
  - start while busy → ignored; sequence completes with the original amount.
  - CargaQ+start together in IDLE → load only.
